// File: rtl/regs_pkg.sv
// Shared constants and types for the register-file writeback slice.
package regs_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned AW       = 5;
    localparam int unsigned NREGS    = 2 ** AW;
    localparam int unsigned ZERO_REG = 0;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_ALU,
        SEL_LOAD
    } wb_sel_e;

endpackage

// File: rtl/wb_fifo.sv
// Circular load-return buffer; pointers carry one extra wrap bit so full and empty are distinct.
module wb_fifo #(
    parameter int unsigned W     = 37,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_push;
    logic         do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is not reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= push_data;
    end

endmodule

// File: rtl/regs_writeback.sv
// Register-file write-port master: arbitrates ALU results against buffered load returns
// and tracks outstanding load destinations.
module regs_writeback #(
    parameter int unsigned XLEN  = regs_pkg::XLEN,
    parameter int unsigned AW    = regs_pkg::AW,
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [AW-1:0]     alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [AW-1:0]     ld_rd,
    input  logic [XLEN-1:0]   ld_data,
    input  logic              ld_issue,
    input  logic [AW-1:0]     ld_issue_rd,
    output logic [AW-1:0]     rd_addr,
    output logic [XLEN-1:0]   rd_data,
    output logic              write_en,
    output logic [2**AW-1:0]  pending
);

    import regs_pkg::*;

    localparam int unsigned NR = 2 ** AW;
    localparam int unsigned DW = AW + XLEN;

    wb_sel_e          sel;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic [DW-1:0]    head;
    logic [AW-1:0]    head_rd;
    logic [XLEN-1:0]  head_data;
    logic [AW-1:0]    wb_rd;
    logic [XLEN-1:0]  wb_data;
    logic             wb_we;
    logic [NR-1:0]    pending_next;

    wb_fifo #(
        .W     (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({ld_rd, ld_data}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head_rd   = head[DW-1:XLEN];
    assign head_data = head[XLEN-1:0];
    assign ld_ready  = !fifo_full;
    assign push      = ld_valid && ld_ready;
    assign pop       = (sel == SEL_LOAD);

    // A full FIFO pre-empts the ALU so loads always make forward progress.
    always_comb begin
        sel       = SEL_NONE;
        alu_ready = 1'b1;
        if (fifo_full) begin
            sel       = SEL_LOAD;
            alu_ready = 1'b0;
        end else if (alu_valid) begin
            sel = SEL_ALU;
        end else if (!fifo_empty) begin
            sel = SEL_LOAD;
        end
    end

    always_comb begin
        wb_rd   = '0;
        wb_data = '0;
        unique case (sel)
            SEL_ALU: begin
                wb_rd   = alu_rd;
                wb_data = alu_data;
            end
            SEL_LOAD: begin
                wb_rd   = head_rd;
                wb_data = head_data;
            end
            default: ;
        endcase
        wb_we = (sel != SEL_NONE) && (wb_rd != AW'(ZERO_REG));
    end

    // Clear for the draining load is applied first so a same-cycle reissue keeps the bit set.
    always_comb begin
        pending_next = pending;
        if (sel == SEL_LOAD) pending_next[head_rd] = 1'b0;
        if (ld_issue) pending_next[ld_issue_rd] = 1'b1;
        pending_next[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr  <= '0;
            rd_data  <= '0;
            write_en <= 1'b0;
            pending  <= '0;
        end else begin
            rd_addr  <= wb_rd;
            rd_data  <= wb_data;
            write_en <= wb_we;
            pending  <= pending_next;
        end
    end

endmodule

// File: tb/tb_regs_writeback.sv
// Self-checking bench for regs_writeback: queue-based reference model plus directed scenarios.
module tb_regs_writeback;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ld_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        ld_issue;
    logic [4:0]  ld_issue_rd;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        write_en;
    logic [31:0] pending;

    regs_writeback #(
        .XLEN  (32),
        .AW    (5),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_rd       (ld_rd),
        .ld_data     (ld_data),
        .ld_issue    (ld_issue),
        .ld_issue_rd (ld_issue_rd),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .write_en    (write_en),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference state: buffered loads, outstanding destinations, and a log of observed writes.
    ld_t         mq[$];
    logic [31:0] mpend;
    logic [4:0]  wlog_rd[$];
    logic [31:0] wlog_data[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive, check readys against the model, advance model, check registered outputs.
    task automatic cycle(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic lv, input logic [4:0] lr, input logic [31:0] ldd,
                         input logic iv, input logic [4:0] ir);
        logic        full;
        logic        has_w;
        logic [4:0]  wr;
        logic [31:0] wd;
        ld_t         e;
        alu_valid   = av;
        alu_rd      = ar;
        alu_data    = ad;
        ld_valid    = lv;
        ld_rd       = lr;
        ld_data     = ldd;
        ld_issue    = iv;
        ld_issue_rd = ir;
        #1;
        full = (mq.size() == DEPTH);
        chk("alu_ready", {63'd0, alu_ready}, {63'd0, !full});
        chk("ld_ready", {63'd0, ld_ready}, {63'd0, !full});
        has_w = 1'b0;
        wr    = '0;
        wd    = '0;
        if (full || (!av && mq.size() != 0)) begin
            e = mq.pop_front();
            wr = e.rd;
            wd = e.data;
            has_w = 1'b1;
            mpend[wr] = 1'b0;
        end else if (av) begin
            wr = ar;
            wd = ad;
            has_w = 1'b1;
        end
        if (lv && !full) begin
            e = {lr, ldd};
            mq.push_back(e);
        end
        if (iv) mpend[ir] = 1'b1;
        mpend[0] = 1'b0;
        @(posedge clk);
        #1;
        chk("write_en", {63'd0, write_en}, {63'd0, (has_w && wr != 5'd0)});
        if (has_w && wr != 5'd0) begin
            chk("rd_addr", {59'd0, rd_addr}, {59'd0, wr});
            chk("rd_data", {32'd0, rd_data}, {32'd0, wd});
        end
        chk("pending", {32'd0, pending}, {32'd0, mpend});
        if (write_en) begin
            wlog_rd.push_back(rd_addr);
            wlog_data.push_back(rd_data);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    endtask

    initial begin
        int ci;
        rst = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h1234;
        ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
        ld_issue = 1'b0; ld_issue_rd = '0;
        mpend = '0;
        #12;
        chk("rst_write_en", {63'd0, write_en}, 64'd0);
        chk("rst_rd_addr", {59'd0, rd_addr}, 64'd0);
        chk("rst_rd_data", {32'd0, rd_data}, 64'd0);
        chk("rst_pending", {32'd0, pending}, 64'd0);
        chk("rst_ld_ready", {63'd0, ld_ready}, 64'd1);
        chk("rst_alu_ready", {63'd0, alu_ready}, 64'd1);
        alu_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // ALU only, then x0 suppression
        cycle(1'b1, 5'd1, 32'h00000001, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        chk("alu1_addr", {59'd0, rd_addr}, 64'd1);
        chk("alu1_data", {32'd0, rd_data}, 64'h1);
        cycle(1'b1, 5'd5, 32'h00000fff, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        chk("alu5_we", {63'd0, write_en}, 64'd1);
        chk("alu5_data", {32'd0, rd_data}, 64'hfff);
        cycle(1'b1, 5'd0, 32'hdeadbeef, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        chk("x0_we", {63'd0, write_en}, 64'd0);

        // Contention: ALU busy while four loads fill the FIFO
        wlog_rd.delete();
        wlog_data.delete();
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 5'd7, $urandom, 1'b1, 5'(2 + i), 32'h00000f0f + i, 1'b0, 5'd0);
        chk("full_ld_ready", {63'd0, ld_ready}, 64'd0);
        chk("full_alu_ready", {63'd0, alu_ready}, 64'd0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 5'd7, $urandom, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        idle(6);
        ci = 0;
        for (int i = 0; i < wlog_rd.size(); i++) begin
            if (wlog_rd[i] >= 5'd2 && wlog_rd[i] <= 5'd5) begin
                chk("cont_order_rd", {59'd0, wlog_rd[i]}, 64'(2 + ci));
                chk("cont_order_data", {32'd0, wlog_data[i]}, 64'(32'h00000f0f + ci));
                ci++;
            end
        end
        chk("cont_count", 64'(ci), 64'd4);

        // Scoreboard set, clear with the write, and set-wins on collision
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6);
        chk("sb_set", {63'd0, pending[6]}, 64'd1);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h66, 1'b0, 5'd0);
        chk("sb_wait", {63'd0, pending[6]}, 64'd1);
        idle(1);
        chk("sb_clr_we", {63'd0, write_en}, 64'd1);
        chk("sb_clr", {63'd0, pending[6]}, 64'd0);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h77, 1'b0, 5'd0);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6);
        chk("sb_win_addr", {59'd0, rd_addr}, 64'd6);
        chk("sb_win", {63'd0, pending[6]}, 64'd1);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h88, 1'b0, 5'd0);
        idle(2);

        // Push and pop together at count DEPTH-1
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 5'd7, $urandom, 1'b1, 5'(8 + i), $urandom, 1'b0, 5'd0);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'hb, 1'b0, 5'd0);
        chk("pp_ld_ready", {63'd0, ld_ready}, 64'd1);
        cycle(1'b1, 5'd7, $urandom, 1'b1, 5'd12, 32'hc, 1'b0, 5'd0);
        chk("pp_full", {63'd0, ld_ready}, 64'd0);
        idle(6);

        // Reset with loads queued and pending bits set
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 5'd7, $urandom, 1'b1, 5'(13 + i), $urandom, 1'b1, 5'(20 + i));
        chk("pre_rst_pending", {63'd0, (pending != 32'd0)}, 64'd1);
        alu_valid = 1'b0; ld_valid = 1'b0; ld_issue = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_we", {63'd0, write_en}, 64'd0);
        chk("mid_rst_pending", {32'd0, pending}, 64'd0);
        chk("mid_rst_ld_ready", {63'd0, ld_ready}, 64'd1);
        mq.delete();
        mpend = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(5);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 1)), 5'($urandom), $urandom,
                  1'($urandom_range(0, 2) != 0), 5'($urandom), $urandom,
                  1'($urandom_range(0, 3) == 0), 5'($urandom));
        idle(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
